lsu_mem_master: RTL and testbench
=================================

LSU_MEM_MASTER -- requirements
Module: lsu_mem_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set max BUSY cycles awaiting mem_ack; 0 SHALL disable timeout.
REQ-002 clk  in  1  single clock; all state SHALL update on posedge clk.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  1  pipeline access request.
REQ-005 req_ready  out  1  block idle and can accept.
REQ-006 req_we  in  1  1=store, 0=load.
REQ-007 req_op  in  3  access size: WORD, HALF, BITE (shared encodings).
REQ-008 req_signed  in  1  load sign-extension select.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, right-aligned.
REQ-011 resp_valid  out  1  one-cycle completion pulse.
REQ-012 resp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-013 resp_err  out  1  misalign/bad-op/timeout flag, valid with resp_valid.
REQ-014 mem_req  out  1  memory access request, held until acked.
REQ-015 mem_we  out  1  write strobe qualifier.
REQ-016 mem_addr  out  32  word address {addr[31:2],2'b00}.
REQ-017 mem_be  out  4  byte enables.
REQ-018 mem_wdata  out  32  lane-replicated store data.
REQ-019 mem_ack  in  1  memory completion, sampled only while mem_req=1.
REQ-020 mem_rdata  in  32  read word, valid when mem_ack=1.

Function
REQ-021 FSM states IDLE, BUSY, RESP; req_ready SHALL be 1 only in IDLE.
REQ-022 Accept when req_valid&&req_ready at edge T; all req_* SHALL be registered at T.
REQ-023 Legal access: BUSY during T+1 with mem_req=1; mem_addr/mem_be/mem_wdata/mem_we SHALL remain stable until ack.
REQ-024 mem_ack=1 in BUSY SHALL capture mem_rdata and go RESP; min latency: resp_valid in T+2, req_ready in T+3.
REQ-025 RESP SHALL last exactly one cycle, then IDLE; no back-to-back acceptance in RESP.
REQ-026 mem_be: WORD 4'b1111; HALF addr[1]=0 -> 4'b0011, 1 -> 4'b1100; BITE 4'b0001<<addr[1:0].
REQ-027 mem_wdata: WORD as-is; HALF {2{wdata[15:0]}}; BITE {4{wdata[7:0]}}.
REQ-028 Loads: select halfword by addr[1], byte by addr[1:0]; zero-extend if req_signed=0, sign-extend if 1; WORD unmodified.
REQ-029 Undefined req_op SHALL skip memory: RESP in T+1 with resp_err=1, resp_rdata=0.
REQ-030 BUSY cycle counter SHALL reset on entry; at TIMEOUT_CYCLES without ack, SHALL drop mem_req and go RESP with resp_err=1.
REQ-031 mem_ack while mem_req=0 SHALL be ignored.
REQ-032 Store response SHALL have resp_rdata=0, resp_err=0.

Reset
REQ-033 reset SHALL force IDLE regardless of state, including mid-BUSY; pending access abandoned, no resp_valid.
REQ-034 Outputs after reset edge: req_ready=1; resp_valid, resp_err, mem_req, mem_we=0; resp_rdata, mem_addr, mem_wdata=0; mem_be=4'b0000.

Configuration
REQ-035 With LSU_ALIGN_CHECK_EN defined: WORD with addr[1:0]!=0 or HALF with addr[0]=1 SHALL skip memory and respond in T+1 with resp_err=1.
REQ-036 Without LSU_ALIGN_CHECK_EN: unused low address bits SHALL be ignored, access issued normally.

Structure
REQ-037 WORD/HALF/BITE encodings and FSM state constants SHALL live in the shared constants header.
REQ-038 Load extraction/extension SHALL be sub-module lsu_ld_ext (combinational: word, addr[1:0], op, signed -> data).

Verification
REQ-039 sw 0x12345678 @0x10, ack next cycle -> mem_be=1111, mem_addr=0x10, resp_valid at T+2, err=0.
REQ-040 sb 0xAB @0x13 -> mem_be=1000, mem_wdata=0xABABABAB; lb signed @0x13 with rdata 0xAB000000 -> resp_rdata=0xFFFFFFAB.
REQ-041 lh unsigned @0x22, rdata 0x8001FFFF -> mem_be=1100, resp_rdata=0x00008001.
REQ-042 lw @0x21 with LSU_ALIGN_CHECK_EN -> no mem_req, resp_err=1 at T+1; without macro -> mem_addr=0x20.
REQ-043 TIMEOUT_CYCLES=4, no ack -> mem_req drops after 4 BUSY cycles, resp_err=1.
REQ-044 reset in 2nd BUSY cycle, late mem_ack next cycle -> IDLE, req_ready=1, no resp_valid.

Source files
------------

// File: rtl/lsu_mem_master_pkg.sv
// Shared constants for the LSU memory master: access-size encodings, FSM states
// and the byte-lane helpers used when a request is accepted.
package lsu_mem_master_pkg;

    localparam logic [2:0] OP_BITE = 3'b000;
    localparam logic [2:0] OP_HALF = 3'b001;
    localparam logic [2:0] OP_WORD = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op == OP_BITE) || (op == OP_HALF) || (op == OP_WORD);
    endfunction

    function automatic logic [3:0] byte_enables(input logic [2:0] op, input logic [1:0] addr_lo);
        logic [3:0] be;
        be = 4'b0000;
        case (op)
            OP_WORD: be = 4'b1111;
            OP_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            OP_BITE: be = 4'b0001 << addr_lo;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Narrow stores are copied into every lane; mem_be picks the lane that lands.
    function automatic logic [31:0] replicate_wdata(input logic [2:0] op, input logic [31:0] wdata);
        logic [31:0] data;
        data = 32'h0;
        case (op)
            OP_WORD: data = wdata;
            OP_HALF: data = {2{wdata[15:0]}};
            OP_BITE: data = {4{wdata[7:0]}};
            default: data = 32'h0;
        endcase
        return data;
    endfunction

endpackage

// File: rtl/lsu_ld_ext.sv
// Combinational load extraction: selects the addressed half/byte of a memory
// word and zero- or sign-extends it to 32 bits.
module lsu_ld_ext
    import lsu_mem_master_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  op,
    input  logic        sign_ext,
    output logic [31:0] data
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    always_comb begin
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
        byte_sel = word[7:0];
        case (addr_lo)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase

        data = word;
        case (op)
            OP_HALF: data = {{16{sign_ext & half_sel[15]}}, half_sel};
            OP_BITE: data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// LSU memory master: one access at a time, IDLE -> BUSY -> RESP.
// Define LSU_ALIGN_CHECK_EN to reject misaligned WORD/HALF accesses without touching memory.
module lsu_mem_master
    import lsu_mem_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_op,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  dbg_state
);

    // Handshake: a request is taken on any posedge where req_valid && req_ready;
    // req_ready is high only in IDLE, so the requester may drop req_valid the cycle after.

    localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 1;

    lsu_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  op_q, op_d;
    logic        sgn_q, sgn_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        misaligned;
    logic [31:0] ld_data;

    lsu_ld_ext u_ld_ext (
        .word     (mem_rdata),
        .addr_lo  (addr_lo_q),
        .op       (op_q),
        .sign_ext (sgn_q),
        .data     (ld_data)
    );

    always_comb begin
`ifdef LSU_ALIGN_CHECK_EN
        misaligned = ((req_op == OP_WORD) && (req_addr[1:0] != 2'b00)) ||
                     ((req_op == OP_HALF) && req_addr[0]);
`else
        misaligned = 1'b0;
`endif
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        op_d        = op_q;
        sgn_d       = sgn_q;
        addr_lo_d   = addr_lo_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        err_d       = err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d        = req_we;
                    op_d        = req_op;
                    sgn_d       = req_signed;
                    addr_lo_d   = req_addr[1:0];
                    mem_addr_d  = {req_addr[31:2], 2'b00};
                    mem_be_d    = byte_enables(req_op, req_addr[1:0]);
                    mem_wdata_d = replicate_wdata(req_op, req_wdata);
                    cnt_d       = 32'd0;
                    rdata_d     = 32'd0;
                    // Rejected requests bypass memory and answer in the very next cycle.
                    if (!op_is_legal(req_op) || misaligned) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (mem_ack) begin
                    rdata_d = we_q ? 32'd0 : ld_data;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (TIMEOUT_EN && (cnt_q == TIMEOUT_LAST)) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else if (TIMEOUT_EN) begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            op_q        <= OP_BITE;
            sgn_q       <= 1'b0;
            addr_lo_q   <= 2'b00;
            mem_addr_q  <= 32'd0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'd0;
            cnt_q       <= 32'd0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            op_q        <= op_d;
            sgn_q       <= sgn_d;
            addr_lo_q   <= addr_lo_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_err   = resp_valid & err_q;
    assign resp_rdata = resp_valid ? rdata_q : 32'd0;
    assign mem_req    = (state_q == ST_BUSY);
    assign mem_we     = mem_req & we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master (TIMEOUT_CYCLES=4); responses are
// predicted into exp_q as {err, rdata} when each request is driven.
module tb_lsu_mem_master;
    import lsu_mem_master_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_op;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];

    typedef struct {
        logic        we;
        logic [2:0]  op;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic [31:0] mwdata;
        logic [31:0] maddr;
        logic [31:0] rrdata;
    } vec_t;

    lsu_mem_master #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_op     (req_op),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds the request for one edge (edge T); returns 1ns into cycle T+1.
    task automatic drive_req(input logic we, input logic [2:0] op, input logic sgn,
                             input logic [31:0] addr, input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_we     = we;
        req_op     = op;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        step();
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_op     = 3'b000;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
    endtask

    function automatic logic [3:0] model_be(input logic [2:0] op, input logic [1:0] a);
        case (op)
            OP_WORD: return 4'b1111;
            OP_HALF: return (a[1] == 1'b0) ? 4'b0011 : 4'b1100;
            OP_BITE: return (a == 2'd0) ? 4'b0001 : (a == 2'd1) ? 4'b0010 :
                            (a == 2'd2) ? 4'b0100 : 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] op, input logic [31:0] w);
        case (op)
            OP_WORD: return w;
            OP_HALF: return {w[15:0], w[15:0]};
            OP_BITE: return {w[7:0], w[7:0], w[7:0], w[7:0]};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] op, input logic sgn,
                                               input logic [1:0] a, input logic [31:0] w);
        logic [31:0] sh;
        case (op)
            OP_HALF: begin
                sh = w >> (a[1] ? 16 : 0);
                return sgn ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
            end
            OP_BITE: begin
                sh = w >> (8 * int'(a));
                return sgn ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
            end
            default: return w;
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if ({req_ready, resp_valid, resp_err, mem_req, mem_we, mem_be} !== 9'b1_0000_0000) begin
            errors++;
            $display("FAIL reset_ctrl: got ready=%b rv=%b err=%b mreq=%b mwe=%b be=%b, expected 1 0 0 0 0 0000",
                     req_ready, resp_valid, resp_err, mem_req, mem_we, mem_be);
        end
        checks++;
        if ({resp_rdata, mem_addr, mem_wdata} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data: got rdata=%h maddr=%h mwdata=%h, expected all zero",
                     resp_rdata, mem_addr, mem_wdata);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_directed();
        vec_t vecs[8];
        logic [32:0] exp;
        vecs[0] = '{1'b1, OP_WORD, 1'b0, 32'h10, 32'h12345678, 32'hDEADBEEF, 4'b1111, 32'h12345678, 32'h10, 32'h0};
        vecs[1] = '{1'b1, OP_BITE, 1'b0, 32'h13, 32'h000000AB, 32'h0,        4'b1000, 32'hABABABAB, 32'h10, 32'h0};
        vecs[2] = '{1'b0, OP_BITE, 1'b1, 32'h13, 32'h0,        32'hAB000000, 4'b1000, 32'h0,        32'h10, 32'hFFFFFFAB};
        vecs[3] = '{1'b0, OP_HALF, 1'b0, 32'h22, 32'h0,        32'h8001FFFF, 4'b1100, 32'h0,        32'h20, 32'h00008001};
        vecs[4] = '{1'b0, OP_HALF, 1'b1, 32'h20, 32'h0,        32'h12348765, 4'b0011, 32'h0,        32'h20, 32'hFFFF8765};
        vecs[5] = '{1'b0, OP_BITE, 1'b0, 32'h11, 32'h0,        32'h0000F100, 4'b0010, 32'h0,        32'h10, 32'h000000F1};
        vecs[6] = '{1'b0, OP_WORD, 1'b1, 32'h40, 32'h0,        32'hCAFEF00D, 4'b1111, 32'h0,        32'h40, 32'hCAFEF00D};
        vecs[7] = '{1'b1, OP_HALF, 1'b0, 32'h46, 32'h5A5AC3D2, 32'h0,        4'b1100, 32'hC3D2C3D2, 32'h44, 32'h0};
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({1'b0, vecs[i].rrdata});
            drive_req(vecs[i].we, vecs[i].op, vecs[i].sgn, vecs[i].addr, vecs[i].wdata);
            checks++;
            if ({req_ready, mem_req, mem_we, mem_be, mem_addr, mem_wdata} !==
                {1'b0, 1'b1, vecs[i].we, vecs[i].be, vecs[i].maddr, vecs[i].mwdata}) begin
                errors++;
                $display("FAIL directed_mem[%0d]: got ready=%b req=%b we=%b be=%b addr=%h wdata=%h, expected 0 1 %b %b %h %h",
                         i, req_ready, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
                         vecs[i].we, vecs[i].be, vecs[i].maddr, vecs[i].mwdata);
            end
            mem_ack   = 1'b1;
            mem_rdata = vecs[i].rdata;
            step();
            mem_ack   = 1'b0;
            mem_rdata = 32'h0;
            exp = exp_q.pop_front();
            checks++;
            if ({resp_valid, resp_err, resp_rdata} !== {1'b1, exp}) begin
                errors++;
                $display("FAIL directed_resp[%0d]: got valid=%b err=%b rdata=%h, expected 1 %b %h",
                         i, resp_valid, resp_err, resp_rdata, exp[32], exp[31:0]);
            end
            step();
            checks++;
            if ({req_ready, resp_valid, mem_req} !== 3'b100) begin
                errors++;
                $display("FAIL directed_idle[%0d]: got ready=%b rv=%b mreq=%b, expected 1 0 0",
                         i, req_ready, resp_valid, mem_req);
            end
        end
    endtask

    task automatic test_bad_op();
        logic [32:0] exp;
        for (int op = 3; op < 8; op++) begin
            exp_q.push_back({1'b1, 32'h0});
            drive_req(1'b0, 3'(op), 1'b0, 32'h100, 32'h0);
            mem_ack   = 1'b1;
            mem_rdata = 32'h55AA55AA;
            exp = exp_q.pop_front();
            checks++;
            if ({mem_req, resp_valid, resp_err, resp_rdata} !== {1'b0, 1'b1, exp}) begin
                errors++;
                $display("FAIL bad_op[%0d]: got mreq=%b valid=%b err=%b rdata=%h, expected 0 1 %b %h",
                         op, mem_req, resp_valid, resp_err, resp_rdata, exp[32], exp[31:0]);
            end
            step();
            mem_ack = 1'b0;
            checks++;
            if ({req_ready, resp_valid} !== 2'b10) begin
                errors++;
                $display("FAIL bad_op_idle[%0d]: got ready=%b rv=%b, expected 1 0", op, req_ready, resp_valid);
            end
        end
    endtask

    task automatic test_misaligned();
        logic [32:0] exp;
`ifdef LSU_ALIGN_CHECK_EN
        exp_q.push_back({1'b1, 32'h0});
        drive_req(1'b0, OP_WORD, 1'b0, 32'h21, 32'h0);
        exp = exp_q.pop_front();
        checks++;
        if ({mem_req, resp_valid, resp_err, resp_rdata} !== {1'b0, 1'b1, exp}) begin
            errors++;
            $display("FAIL misaligned_lw: got mreq=%b valid=%b err=%b rdata=%h, expected 0 1 1 00000000",
                     mem_req, resp_valid, resp_err, resp_rdata);
        end
        step();
`else
        exp_q.push_back({1'b0, 32'h89ABCDEF});
        drive_req(1'b0, OP_WORD, 1'b0, 32'h21, 32'h0);
        checks++;
        if ({mem_req, mem_addr, mem_be} !== {1'b1, 32'h20, 4'b1111}) begin
            errors++;
            $display("FAIL misaligned_lw_mem: got mreq=%b addr=%h be=%b, expected 1 00000020 1111",
                     mem_req, mem_addr, mem_be);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'h89ABCDEF;
        step();
        mem_ack   = 1'b0;
        exp = exp_q.pop_front();
        checks++;
        if ({resp_valid, resp_err, resp_rdata} !== {1'b1, exp}) begin
            errors++;
            $display("FAIL misaligned_lw_resp: got valid=%b err=%b rdata=%h, expected 1 %b %h",
                     resp_valid, resp_err, resp_rdata, exp[32], exp[31:0]);
        end
        step();
`endif
    endtask

    task automatic test_timeout();
        logic [32:0] exp;
        exp_q.push_back({1'b1, 32'h0});
        drive_req(1'b0, OP_WORD, 1'b0, 32'h200, 32'h0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({mem_req, resp_valid, mem_addr} !== {1'b1, 1'b0, 32'h200}) begin
                errors++;
                $display("FAIL timeout_busy[%0d]: got mreq=%b rv=%b addr=%h, expected 1 0 00000200",
                         i, mem_req, resp_valid, mem_addr);
            end
            step();
        end
        exp = exp_q.pop_front();
        checks++;
        if ({mem_req, resp_valid, resp_err, resp_rdata} !== {1'b0, 1'b1, exp}) begin
            errors++;
            $display("FAIL timeout_resp: got mreq=%b valid=%b err=%b rdata=%h, expected 0 1 1 00000000",
                     mem_req, resp_valid, resp_err, resp_rdata);
        end
        step();
    endtask

    task automatic test_reset_mid_busy();
        drive_req(1'b1, OP_WORD, 1'b0, 32'h300, 32'hFEEDFACE);
        step();
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_busy_pre: got mreq=%b, expected 1", mem_req);
        end
        reset = 1'b1;
        step();
        reset     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h11111111;
        checks++;
        if ({req_ready, resp_valid, mem_req} !== 3'b100) begin
            errors++;
            $display("FAIL rst_busy_idle: got ready=%b rv=%b mreq=%b, expected 1 0 0",
                     req_ready, resp_valid, mem_req);
        end
        step();
        mem_ack = 1'b0;
        checks++;
        if ({req_ready, resp_valid, mem_req} !== 3'b100) begin
            errors++;
            $display("FAIL rst_busy_late_ack: got ready=%b rv=%b mreq=%b, expected 1 0 0",
                     req_ready, resp_valid, mem_req);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ops[3];
        logic [2:0]  op;
        logic        we;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        logic [32:0] exp;
        ops[0] = OP_BITE;
        ops[1] = OP_HALF;
        ops[2] = OP_WORD;
        for (int n = 0; n < 24; n++) begin
            op    = ops[$urandom_range(0, 2)];
            we    = 1'($urandom_range(0, 1));
            sgn   = 1'($urandom_range(0, 1));
            addr  = $urandom();
            wdata = $urandom();
            rdata = $urandom();
            delay = $urandom_range(0, 2);
            if (op == OP_WORD) addr[1:0] = 2'b00;
            if (op == OP_HALF) addr[0] = 1'b0;
            exp_q.push_back({1'b0, we ? 32'h0 : model_load(op, sgn, addr[1:0], rdata)});
            drive_req(we, op, sgn, addr, wdata);
            for (int c = 0; c <= delay; c++) begin
                checks++;
                if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !==
                    {1'b1, we, model_be(op, addr[1:0]), addr & 32'hFFFFFFFC, model_wdata(op, wdata)}) begin
                    errors++;
                    $display("FAIL b2b_mem[%0d.%0d]: got req=%b we=%b be=%b addr=%h wdata=%h, expected 1 %b %b %h %h",
                             n, c, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
                             we, model_be(op, addr[1:0]), addr & 32'hFFFFFFFC, model_wdata(op, wdata));
                end
                mem_ack   = (c == delay);
                mem_rdata = (c == delay) ? rdata : ~rdata;
                step();
            end
            mem_ack   = 1'b0;
            mem_rdata = 32'h0;
            exp = exp_q.pop_front();
            checks++;
            if ({resp_valid, resp_err, resp_rdata} !== {1'b1, exp}) begin
                errors++;
                $display("FAIL b2b_resp[%0d]: got valid=%b err=%b rdata=%h, expected 1 %b %h",
                         n, resp_valid, resp_err, resp_rdata, exp[32], exp[31:0]);
            end
            step();
        end
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_op     = 3'b000;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'h0;

        test_reset();
        test_directed();
        test_bad_op();
        test_misaligned();
        test_timeout();
        test_reset_mid_busy();
        test_back_to_back();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
